seg_scan_mux: RTL and testbench

- Downstream display stage for the LFSR/bit-pattern blocks that produce eight per-digit segment bytes.
- Captures eight 8-bit segment patterns into a double buffer and time-multiplexes them onto one shared segment bus with a one-hot digit-enable.
- Needed for boards whose eight digits share one segment bus.
- Updates are applied only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seg_pkg.sv | 11 +
 rtl/seg_prescaler.sv | 31 +++
 rtl/seg_scan_mux.sv | 140 ++++++++++++++
 tb/tb_seg_scan_mux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the segment display blocks: blank code, digit count
// and the per-digit segment byte types.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         N_DIGITS  = 8;

    typedef logic [7:0] seg_t;
    typedef seg_t       seg_arr_t [N_DIGITS];

endpackage

// File: rtl/seg_prescaler.sv
// Free-running slot prescaler: counts 0..DIV-1 and flags the last cycle of
// each slot with tick. Shared by several display scanners.
module seg_prescaler #(
    parameter  int DIV = 4096,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          tick,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    // Tick marks the final cycle of a slot, so the wrap and the tick coincide.
    always_comb begin
        tick = (cnt == LAST);
    end

    // Slot counter with wrap at DIV-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Eight-digit segment scanner: double-buffered capture of eight active-low
// segment bytes, frame-aligned buffer swap, and time-multiplexed drive of a
// shared segment bus with one-hot active-low digit enables.
// Optional build macro SCAN_BLANK_EN: blanks the first BLANK cycles of each
// digit slot (anti-ghosting dead time); without it BLANK is ignored.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIV   = 4096,
    parameter int BLANK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] seg_in,
    input  logic        load,
    output logic [7:0]  seg_out,
    output logic [7:0]  an,
    output logic        frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic          tick;
    logic [CW-1:0] presc_cnt;
    logic [2:0]    idx;
    logic [2:0]    next_idx;
    logic          boundary;
    logic          blank_next;
    logic          pend_valid;
    seg_arr_t      pending;
    seg_arr_t      active;
    seg_arr_t      next_active;
    seg_arr_t      seg_in_arr;

    seg_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .cnt  (presc_cnt)
    );

    // Split the flat input bus into one byte per digit.
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            seg_in_arr[i] = seg_in[8*i +: 8];
        end
    end

    // Digit index advance and frame boundary (last cycle of digit 7's slot).
    always_comb begin
        boundary = tick && (idx == 3'd7);
        next_idx = idx;
        if (tick) begin
            next_idx = (idx == 3'd7) ? 3'd0 : idx + 3'd1;
        end
    end

    // Buffer contents after this edge; a load on the boundary bypasses pending.
    always_comb begin
        next_active = active;
        if (boundary) begin
            if (load) begin
                next_active = seg_in_arr;
            end else if (pend_valid) begin
                next_active = pending;
            end
        end
    end

`ifdef SCAN_BLANK_EN
    logic [CW-1:0] next_cnt;

    // Dead time covers the first BLANK cycles of every slot, judged on the
    // prescaler value the registered outputs will line up with.
    always_comb begin
        next_cnt   = tick ? '0 : presc_cnt + 1'b1;
        blank_next = (next_cnt < CW'(BLANK));
    end
`else
    logic unused_presc;

    // No dead time; the slot position is not needed here.
    always_comb begin
        unused_presc = ^presc_cnt;
        blank_next   = 1'b0;
    end
`endif

    // Pending capture and frame-aligned transfer into the active buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                pending[i] <= SEG_BLANK;
                active[i]  <= SEG_BLANK;
            end
            pend_valid <= 1'b0;
        end else begin
            active <= next_active;
            if (load) begin
                pending <= seg_in_arr;
            end
            if (boundary) begin
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // Digit index register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= 3'd0;
        end else begin
            idx <= next_idx;
        end
    end

    // Registered bus drive from the next-state index and buffer, so new data
    // appears on digit 0 on the same edge the index wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_out    <= SEG_BLANK;
            an         <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (blank_next) begin
                seg_out <= SEG_BLANK;
                an      <= 8'hFF;
            end else begin
                seg_out <= next_active[next_idx];
                an      <= ~(8'b1 << next_idx);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux with DIV=4, BLANK=1. A time-based
// reference model queues the expected outputs at each rising edge; they are
// popped and compared on the following falling edge.
module tb_seg_scan_mux;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 8 * DIV;

    typedef struct {
        logic [7:0] seg;
        logic [7:0] an;
        logic       fd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [63:0] seg_in;
    logic        load;
    logic [7:0]  seg_out;
    logic [7:0]  an;
    logic        frame_done;

    int checkCount = 0;
    int passCount  = 0;

    exp_t expQ[$];

    // Reference model state: edges since reset release and the buffers.
    int         n = 0;
    int         mIdx = 0;
    int         mPres = 0;
    logic [7:0] mAct  [8];
    logic [7:0] mPend [8];
    logic       mPendV = 1'b0;

    int cyc    = 0;
    int lastFd = -1;

    seg_scan_mux #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .load       (load),
        .seg_out    (seg_out),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: slot position derived from the edge count since reset.
    always @(posedge clk) begin
        exp_t e;
        logic blank;
        if (!rst) begin
            n = 0;
            for (int i = 0; i < 8; i++) begin
                mAct[i]  = 8'hFF;
                mPend[i] = 8'hFF;
            end
            mPendV = 1'b0;
            mIdx   = 0;
            mPres  = 0;
            e.seg  = 8'hFF;
            e.an   = 8'hFF;
            e.fd   = 1'b0;
        end else begin
            n++;
            if (n % FRAME == 0) begin
                if (load) begin
                    for (int i = 0; i < 8; i++) mAct[i] = seg_in[8*i +: 8];
                end else if (mPendV) begin
                    for (int i = 0; i < 8; i++) mAct[i] = mPend[i];
                end
                mPendV = 1'b0;
            end else if (load) begin
                for (int i = 0; i < 8; i++) mPend[i] = seg_in[8*i +: 8];
                mPendV = 1'b1;
            end
            mPres = n % DIV;
            mIdx  = (n / DIV) % 8;
`ifdef SCAN_BLANK_EN
            blank = (mPres < BLANK);
`else
            blank = 1'b0;
`endif
            e.seg = blank ? 8'hFF : mAct[mIdx];
            e.an  = blank ? 8'hFF : ~(8'h01 << mIdx);
            e.fd  = (n % FRAME == 0);
        end
        expQ.push_back(e);
    end

    // Scoreboard compare plus frame_done period tracking.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (expQ.size() == 0) begin
            checkOutput("queue_empty", 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput("seg_out", {24'd0, seg_out}, {24'd0, e.seg});
            checkOutput("an", {24'd0, an}, {24'd0, e.an});
            checkOutput("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
        end
        if (!rst) begin
            lastFd = -1;
        end else if (frame_done) begin
            if (lastFd >= 0) checkOutput("fd_period", 32'(cyc - lastFd), 32'(FRAME));
            lastFd = cyc;
        end
    end

    task automatic applyStimulus(input logic [63:0] data);
        load   = 1'b1;
        seg_in = data;
        @(negedge clk);
        load   = 1'b0;
        seg_in = 64'h0;
    endtask

    task automatic waitFor(input int idx, input int pres);
        for (int k = 0; k < 300; k++) begin
            if (mIdx == idx && mPres == pres) return;
            @(negedge clk);
        end
        checkOutput("wait_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [63:0] fillAll(input logic [7:0] b);
        return {8{b}};
    endfunction

    initial begin
        logic [63:0] ramp;
        rst    = 1'b0;
        load   = 1'b0;
        seg_in = 64'h0;
        for (int i = 0; i < 8; i++) ramp[8*i +: 8] = 8'h10 + 8'(i);

        // Reset hold
        repeat (3) @(negedge clk);
        checkOutput("rst_seg", {24'd0, seg_out}, 32'hFF);
        checkOutput("rst_an", {24'd0, an}, 32'hFF);
        rst = 1'b1;

        // Mid-frame load, visible from the next frame
        waitFor(3, 0);
        applyStimulus(ramp);
        waitFor(0, 0);
        checkOutput("bnd_fd", {31'd0, frame_done}, 32'd1);
`ifndef SCAN_BLANK_EN
        checkOutput("bnd_an", {24'd0, an}, 32'hFE);
        checkOutput("bnd_seg", {24'd0, seg_out}, 32'h10);
`endif
        waitFor(3, 1);
        checkOutput("ramp_d3", {24'd0, seg_out}, 32'h13);

        // Overwrite: last load before the boundary wins
        waitFor(2, 0);
        applyStimulus(fillAll(8'hAA));
        waitFor(5, 0);
        applyStimulus(fillAll(8'h55));
        waitFor(0, 1);
        checkOutput("ovr_an", {24'd0, an}, 32'hFE);
        checkOutput("ovr_seg", {24'd0, seg_out}, 32'h55);

        // Load on the boundary cycle bypasses pending
        waitFor(7, 3);
        applyStimulus(fillAll(8'h9E));
`ifndef SCAN_BLANK_EN
        checkOutput("byp_seg0", {24'd0, seg_out}, 32'h9E);
`endif
        waitFor(0, 1);
        checkOutput("byp_seg", {24'd0, seg_out}, 32'h9E);
        checkOutput("byp_an", {24'd0, an}, 32'hFE);

        // Pending data then async reset mid-scan
        waitFor(4, 0);
        applyStimulus(fillAll(8'h3C));
        waitFor(5, 2);
        #1 rst = 1'b0;
        #1;
        checkOutput("arst_seg", {24'd0, seg_out}, 32'hFF);
        checkOutput("arst_an", {24'd0, an}, 32'hFF);
        checkOutput("arst_fd", {31'd0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Scan restarts at digit 0 and pending data is gone
        waitFor(0, 1);
        checkOutput("rest_an", {24'd0, an}, 32'hFE);
        waitFor(7, 3);
        @(negedge clk);
        waitFor(0, 1);
        checkOutput("rest_seg", {24'd0, seg_out}, 32'hFF);
        repeat (FRAME + 4) @(negedge clk);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
